pipeline_stage_reg: RTL and testbench

//  Generic inter-stage pipeline register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_stage_reg.sv | 87 ++++++++
 tb/tb_pipeline_stage_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register with stall hold, bubble insertion, flush, a sticky
// stall-protocol error flag and a saturating stall-cycle counter.
module pipeline_stage_reg #(
   parameter int unsigned       WIDTH        = 32,
   parameter logic [WIDTH-1:0]  BUBBLE_VALUE = '0,
   parameter int unsigned       CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_current_stage,
   input  logic                 stall_next_stage,
   input  logic                 flush,
   input  logic                 valid_in,
   input  logic [WIDTH-1:0]     data_in,
   input  logic                 clr_stats,
   output logic                 valid_out,
   output logic [WIDTH-1:0]     data_out,
   output logic                 bubble_out,
   output logic                 protocol_err,
   output logic [CNT_WIDTH-1:0] stall_cycles
);

   logic [WIDTH-1:0]     data_d, data_q;
   logic                 valid_d, valid_q;
   logic                 bubble_d, bubble_q;
   logic                 err_d, err_q;
   logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

   always_comb begin
      data_d   = data_q;
      valid_d  = valid_q;
      bubble_d = bubble_q;
      err_d    = err_q;
      cnt_d    = cnt_q;

      if (flush) begin
         data_d   = BUBBLE_VALUE;
         valid_d  = 1'b0;
         bubble_d = 1'b1;
      end else if (stall_next_stage) begin
         // Hold; only count cycles that actually delay a real instruction.
         if (valid_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (stall_current_stage) begin
         data_d   = BUBBLE_VALUE;
         valid_d  = 1'b0;
         bubble_d = 1'b1;
      end else begin
         data_d   = data_in;
         valid_d  = valid_in;
         bubble_d = 1'b0;
      end

      if (!stall_current_stage && stall_next_stage) begin
         err_d = 1'b1;
      end

      if (clr_stats) begin
         err_d = 1'b0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q   <= BUBBLE_VALUE;
         valid_q  <= 1'b0;
         bubble_q <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         data_q   <= data_d;
         valid_q  <= valid_d;
         bubble_q <= bubble_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   assign data_out     = data_q;
   assign valid_out    = valid_q;
   assign bubble_out   = bubble_q;
   assign protocol_err = err_q;
   assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed and randomized checks of pipeline_stage_reg against a priority-rule model;
// a second instance with a 2-bit counter and a NOP bubble value covers saturation.
module tb_pipeline_stage_reg;

   localparam logic [31:0] Bub1 = 32'h0000_0000;
   localparam logic [31:0] Bub2 = 32'h0000_0013;
   localparam int          Sat1 = 65535;
   localparam int          Sat2 = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sc = 1'b0, sn = 1'b0, fl = 1'b0, vi = 1'b0, clr = 1'b0;
   logic [31:0] di = '0;

   logic        valid1, bubble1, err1, valid2, bubble2, err2;
   logic [31:0] data1, data2;
   logic [15:0] cnt1;
   logic [1:0]  cnt2;

   int errors = 0;
   int checks = 0;

   // Model state
   logic [31:0] m_data1, m_data2;
   logic        m_valid, m_bub, m_err;
   int          m_cnt1, m_cnt2;

   always #5 clk = ~clk;

   pipeline_stage_reg #(.WIDTH(32), .BUBBLE_VALUE(Bub1), .CNT_WIDTH(16)) u_dut1 (
      .clk(clk), .rst(rst), .stall_current_stage(sc), .stall_next_stage(sn), .flush(fl),
      .valid_in(vi), .data_in(di), .clr_stats(clr), .valid_out(valid1), .data_out(data1),
      .bubble_out(bubble1), .protocol_err(err1), .stall_cycles(cnt1)
   );

   pipeline_stage_reg #(.WIDTH(32), .BUBBLE_VALUE(Bub2), .CNT_WIDTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .stall_current_stage(sc), .stall_next_stage(sn), .flush(fl),
      .valid_in(vi), .data_in(di), .clr_stats(clr), .valid_out(valid2), .data_out(data2),
      .bubble_out(bubble2), .protocol_err(err2), .stall_cycles(cnt2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".data1"}, data1, m_data1);
      check({tag, ".valid1"}, {31'd0, valid1}, {31'd0, m_valid});
      check({tag, ".bubble1"}, {31'd0, bubble1}, {31'd0, m_bub});
      check({tag, ".err1"}, {31'd0, err1}, {31'd0, m_err});
      check({tag, ".cnt1"}, {16'd0, cnt1}, m_cnt1);
      check({tag, ".data2"}, data2, m_data2);
      check({tag, ".valid2"}, {31'd0, valid2}, {31'd0, m_valid});
      check({tag, ".cnt2"}, {30'd0, cnt2}, m_cnt2);
      check({tag, ".err2"}, {31'd0, err2}, {31'd0, m_err});
   endtask

   task automatic model_reset();
      m_data1 = Bub1; m_data2 = Bub2;
      m_valid = 1'b0; m_bub = 1'b0; m_err = 1'b0;
      m_cnt1 = 0; m_cnt2 = 0;
   endtask

   // Drive one cycle of inputs, advance the model by the priority rules, clock, then sample.
   task automatic step(input logic s_c, input logic s_n, input logic f, input logic v,
                       input logic [31:0] d, input logic c);
      sc = s_c; sn = s_n; fl = f; vi = v; di = d; clr = c;
      if (f) begin
         m_data1 = Bub1; m_data2 = Bub2; m_valid = 1'b0; m_bub = 1'b1;
      end else if (s_n) begin
         if (m_valid) begin
            m_cnt1 = (m_cnt1 < Sat1) ? m_cnt1 + 1 : Sat1;
            m_cnt2 = (m_cnt2 < Sat2) ? m_cnt2 + 1 : Sat2;
         end
      end else if (s_c) begin
         m_data1 = Bub1; m_data2 = Bub2; m_valid = 1'b0; m_bub = 1'b1;
      end else begin
         m_data1 = d; m_data2 = d; m_valid = v; m_bub = 1'b0;
      end
      if (!s_c && s_n) m_err = 1'b1;
      if (c) begin
         m_err = 1'b0; m_cnt1 = 0; m_cnt2 = 0;
      end
      @(posedge clk);
      #1;
   endtask

   int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

   initial begin
      model_reset();
      #12;
      check_all("reset_initial");
      rst = 1'b1;

      // T1: async reset in the middle of a stream
      step(0, 0, 0, 1, 32'h1234, 0);
      check_all("t1_load1234");
      #2 rst = 1'b0;
      #1 model_reset();
      check_all("t1_async_reset");
      #1 rst = 1'b1;
      step(0, 0, 0, 1, 32'hDEADBEEF, 0);
      check_all("t1_load_deadbeef");

      // T2: legal hold of a full entry for 3 edges
      step(0, 0, 0, 1, 32'hA5A5A5A5, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 1, 32'h1111_0000 + i, 0);
         check_all("t2_hold");
      end
      check("t2_cnt_is_3", {16'd0, cnt1}, 32'd3);
      check("t2_data_held", data1, 32'hA5A5A5A5);
      step(0, 0, 0, 1, 32'h0BAD_F00D, 0);
      check_all("t2_release");

      // T3: bubble insertion then normal load
      step(1, 0, 0, 1, 32'h2222_2222, 0);
      check_all("t3_bubble");
      step(0, 0, 0, 1, 32'h3333_3333, 0);
      check_all("t3_load_after_bubble");

      // T4: flush beats a downstream stall
      step(1, 1, 1, 1, 32'h4444_4444, 0);
      check_all("t4_flush_over_stall");

      // T5: illegal combo sets sticky error; clear wins in the same cycle
      step(0, 0, 0, 1, 32'h5555_5555, 0);
      step(0, 1, 0, 1, 32'h6666_6666, 0);
      check_all("t5_illegal");
      check("t5_err_set", {31'd0, err1}, 32'd1);
      step(1, 0, 0, 1, 32'h7777_7777, 0);
      check_all("t5_err_sticky");
      step(0, 0, 0, 1, 32'h8888_8888, 0);
      step(0, 1, 0, 1, 32'h9999_9999, 1);
      check_all("t5_clr_priority");
      check("t5_err_cleared", {31'd0, err1}, 32'd0);

      // T6: 2-bit counter saturation
      step(0, 0, 0, 1, 32'hCAFE_0006, 1);
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 0, 0, 32'h0, 0);
         check("t6_sat_seq", {30'd0, cnt2}, sat_exp[i]);
      end
      check_all("t6_end");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic r_sc, r_sn, r_f, r_v, r_c;
         r_sn = ($urandom_range(0, 99) < 35);
         r_sc = r_sn ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 20);
         r_f  = ($urandom_range(0, 99) < 6);
         r_v  = ($urandom_range(0, 99) < 75);
         r_c  = ($urandom_range(0, 99) < 4);
         step(r_sc, r_sn, r_f, r_v, $urandom, r_c);
         check_all("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
